decoder_pipe: RTL

Parametrised, registered binary-to-vector decoder with a valid/ready handshake on both sides. It generalises the fixed 3-to-8 one-hot decoder to IN_W-bit codes driving NUM_OUT outputs. It adds three modes: thermometer, multi-beat one-hot sweep, and out-of-range error flagging in place of X outputs. It sits between control logic issuing select codes and downstream enable/strobe consumers that may stall.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/decoder_pipe_if.sv | 26 ++
 rtl/decoder_pipe_core.sv | 30 +++
 rtl/decoder_pipe.sv | 122 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the pipelined code decoder: command modes and output FSM states.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_pipe_if.sv
// Command and beat handshake bundle between a code issuer and the decoder.
interface decoder_pipe_if #(
  parameter int IN_W    = 3,
  parameter int NUM_OUT = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_code;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_vec;
  logic               out_err;
  logic               out_last;
  logic               busy;

  modport master (
    output in_valid, in_code, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_err, out_last, busy
  );

  modport slave (
    input  in_valid, in_code, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_err, out_last, busy
  );
endinterface

// File: rtl/decoder_pipe_core.sv
// Combinational code-to-vector decode; illegal codes/modes yield a zero vector with err set.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W      = 3,
  parameter int NUM_OUT   = 8,
  parameter bit THERMO_EN = 1'b1
) (
  input  logic [IN_W-1:0]    code_i,
  input  mode_e              mode_i,
  output logic [NUM_OUT-1:0] vec_o,
  output logic               err_o
);

  // Error check takes priority over any mode decoding.
  always_comb begin
    vec_o = '0;
    err_o = 1'b0;
    if ((32'(code_i) >= 32'(NUM_OUT)) || (mode_i == MODE_RSVD) ||
        ((mode_i == MODE_THERMO) && !THERMO_EN)) begin
      err_o = 1'b1;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (mode_i == MODE_THERMO) vec_o[i] = (32'(i) <= 32'(code_i));
        else                       vec_o[i] = (32'(i) == 32'(code_i));
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with valid/ready on both sides and multi-beat one-hot sweep.
//
// state | meaning
// IDLE  | no beat presented (out_valid=0)
// HOLD  | single or final sweep beat presented
// SWEEP | non-final sweep beat presented, more beats follow
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W      = 3,
  parameter int NUM_OUT   = 8,
  parameter bit THERMO_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  decoder_pipe_if.slave bus
);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]    k_q, k_d;
  logic [NUM_OUT-1:0] vec_q, vec_d;
  logic               err_q, err_d;
  logic               last_q, last_d;

  logic               out_valid, busy, accept, xfer;
  logic [IN_W-1:0]    cnt_inc, sweep_code;
  logic [NUM_OUT-1:0] cmd_vec, sweep_vec;
  logic               cmd_err, sweep_err;
  mode_e              cmd_mode;

  assign cmd_mode   = mode_e'(bus.in_mode);
  assign out_valid  = (state_q != IDLE);
  assign busy       = (state_q == SWEEP);
  assign bus.in_ready = !rst && !busy && (!out_valid || bus.out_ready);
  assign accept     = bus.in_valid && bus.in_ready;
  assign xfer       = out_valid && bus.out_ready;

  // A new sweep starts at beat 0; inside a sweep the next beat index is loaded.
  assign cnt_inc    = cnt_q + IN_W'(1);
  assign sweep_code = (state_q == SWEEP) ? cnt_inc : '0;

  decoder_core #(.IN_W(IN_W), .NUM_OUT(NUM_OUT), .THERMO_EN(THERMO_EN)) u_cmd (
    .code_i (bus.in_code),
    .mode_i (cmd_mode),
    .vec_o  (cmd_vec),
    .err_o  (cmd_err)
  );

  decoder_core #(.IN_W(IN_W), .NUM_OUT(NUM_OUT), .THERMO_EN(THERMO_EN)) u_sweep (
    .code_i (sweep_code),
    .mode_i (MODE_ONEHOT),
    .vec_o  (sweep_vec),
    .err_o  (sweep_err)
  );

  // Next-state and next-beat selection; everything holds while stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    vec_d   = vec_q;
    err_d   = err_q;
    last_d  = last_q;
    case (state_q)
      SWEEP: begin
        if (xfer) begin
          cnt_d   = cnt_inc;
          vec_d   = sweep_vec;
          err_d   = sweep_err;
          last_d  = (cnt_inc == k_q);
          state_d = last_d ? HOLD : SWEEP;
        end
      end
      default: begin
        if (accept) begin
          if (!cmd_err && (cmd_mode == MODE_SWEEP) && (bus.in_code != '0)) begin
            cnt_d   = '0;
            k_d     = bus.in_code;
            vec_d   = sweep_vec;
            err_d   = sweep_err;
            last_d  = 1'b0;
            state_d = SWEEP;
          end else begin
            vec_d   = cmd_vec;
            err_d   = cmd_err;
            last_d  = 1'b1;
            state_d = HOLD;
          end
        end else if (xfer) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Output register, FSM and sweep counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_vec   = vec_q;
  assign bus.out_err   = err_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy;

endmodule
